controller_sysid_checker: RTL and testbench

CONTROLLER_SYSID_CHECKER -- requirements
Module: controller_sysid_checker

---
 rtl/controller_sysid_pkg.sv | 19 +
 rtl/controller_sysid_if.sv | 19 +
 rtl/controller_sysid_stall_timer.sv | 31 +++
 rtl/controller_sysid_checker.sv | 116 +++++++++++
 tb/tb_controller_sysid_checker.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/controller_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM encoding, word
// addresses of the sysid slave and the default expected contents.
package controller_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd49153;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1531282209;
  localparam int          DEFAULT_TIMEOUT_CYCLES     = 255;

endpackage

// File: rtl/controller_sysid_if.sv
// Avalon-MM read-only port between the checker (master) and a sysid slave.
interface controller_sysid_if;

  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read,
    output waitrequest, readdata
  );

endinterface

// File: rtl/controller_sysid_stall_timer.sv
// Counts waitrequest stalls within one read and flags when the stall limit is
// hit while the slave is still stalling. A limit of 0 never expires.
module controller_sysid_stall_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && stall && (count == LIMIT);

endmodule

// File: rtl/controller_sysid_checker.sv
// Reads the ID and timestamp words of a sysid slave, compares them with the
// expected build values and reports the result, aborting on a stalled slave.
module controller_sysid_checker
  import controller_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  controller_sysid_if.master        avm,
  output logic                      busy,
  output logic                      done,
  output logic                      id_ok,
  output logic                      ts_ok,
  output logic                      timeout,
  output logic [31:0]               id_value,
  output logic [31:0]               ts_value
);

  state_t      state, state_next;
  logic        auto_pending;
  logic        in_read;
  logic        accept;
  logic        stall;
  logic        expired;
  logic        timer_clear;
  logic [31:0] id_capture;

  assign in_read = (state == RD_ID) || (state == RD_TS);
  assign accept  = in_read && !avm.waitrequest;
  assign stall   = in_read &&  avm.waitrequest;

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  // The counter restarts on every state change, so each read gets a full budget.
  assign timer_clear = (state_next != state);

  controller_sysid_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .stall  (stall),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      auto_pending <= AUTO_START;
    end else begin
      state        <= state_next;
      auto_pending <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    avm.read    = 1'b0;
    avm.address = SYSID_ADDR_ID;
    case (state)
      IDLE: begin
        if (start || auto_pending) state_next = RD_ID;
      end
      RD_ID: begin
        avm.read = 1'b1;
        if (accept)       state_next = RD_TS;
        else if (expired) state_next = FINISH;
      end
      RD_TS: begin
        avm.read    = 1'b1;
        avm.address = SYSID_ADDR_TS;
        if (accept || expired) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are written on the edge into FINISH so they are already valid
  // while done is high, then held until the next check finishes.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_capture <= '0;
      id_value   <= '0;
      ts_value   <= '0;
      id_ok      <= 1'b0;
      ts_ok      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (state == RD_ID && accept) id_capture <= avm.readdata;
      if (state == RD_TS && accept) begin
        id_value <= id_capture;
        ts_value <= avm.readdata;
        id_ok    <= (id_capture == EXPECTED_ID);
        ts_ok    <= (avm.readdata == EXPECTED_TIMESTAMP);
        timeout  <= 1'b0;
      end else if (expired) begin
        id_value <= (state == RD_TS) ? id_capture : 32'd0;
        ts_value <= 32'd0;
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
        timeout  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_controller_sysid_checker.sv
// Directed and randomized checks of controller_sysid_checker against a
// per-check behavioural model of read lengths, results and done timing.
module tb_controller_sysid_checker;
  import controller_sysid_pkg::*;

  localparam int          T      = 4;
  localparam logic [31:0] EXP_ID = 32'd49153;
  localparam logic [31:0] EXP_TS = 32'd1531282209;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int checks   = 0;
  int failures = 0;

  controller_sysid_if avm ();

  controller_sysid_checker #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .avm     (avm),
    .busy    (busy),
    .done    (done),
    .id_ok   (id_ok),
    .ts_ok   (ts_ok),
    .timeout (timeout),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle (or in its first post-reset
  // cycle); that cycle is N. The slave stalls wid/wts cycles on each word.
  task automatic run_check(input string name, input int wid, input int wts,
                           input logic [31:0] did, input logic [31:0] dts,
                           input bit pulse, input int extra_k);
    int a, b, exp_k, done_k, ids, tss, rd_id, rd_ts, idle_cycles;
    bit to;
    logic [31:0] eid, ets;

    if (T > 0 && wid > T) begin
      to = 1; a = T + 1; b = 0; eid = 0; ets = 0;
    end else begin
      a = wid + 1; eid = did;
      if (T > 0 && wts > T) begin
        to = 1; b = T + 1; ets = 0;
      end else begin
        to = 0; b = wts + 1; ets = dts;
      end
    end
    exp_k = 1 + a + b;

    start = pulse;
    avm.waitrequest = 1'b0;
    avm.readdata = $urandom;
    ids = 0; tss = 0; rd_id = 0; rd_ts = 0; idle_cycles = 0; done_k = 0;

    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(negedge clock);
      start = (k == extra_k);
      if (!busy) idle_cycles++;
      avm.waitrequest = 1'b0;
      avm.readdata = $urandom;
      if (avm.read && avm.address == SYSID_ADDR_ID) begin
        rd_id++;
        avm.waitrequest = (ids < wid);
        if (ids < wid) ids++; else avm.readdata = did;
      end else if (avm.read) begin
        rd_ts++;
        avm.waitrequest = (tss < wts);
        if (tss < wts) tss++; else avm.readdata = dts;
      end
      if (done) done_k = k;
    end
    start = 1'b0;

    check({name, "_done_cycle"}, done_k, exp_k);
    if (done_k != 0) begin
      check({name, "_busy_gaps"}, idle_cycles, 0);
      check({name, "_id_reads"}, rd_id, a);
      check({name, "_ts_reads"}, rd_ts, b);
      check({name, "_id_ok"}, id_ok, !to && eid == EXP_ID);
      check({name, "_ts_ok"}, ts_ok, !to && ets == EXP_TS);
      check({name, "_timeout"}, timeout, to);
      check({name, "_id_value"}, id_value, eid);
      check({name, "_ts_value"}, ts_value, ets);
    end
    @(negedge clock);
    check({name, "_done_single"}, done, 1'b0);
    check({name, "_idle_after"}, busy, 1'b0);
    @(negedge clock);
    check({name, "_no_requeue"}, busy, 1'b0);
    check({name, "_held_id_value"}, id_value, eid);
  endtask

  initial begin
    int wid, wts;
    logic [31:0] did, dts;

    reset = 1'b1;
    start = 1'b0;
    avm.waitrequest = 1'b0;
    avm.readdata = '0;
    repeat (3) @(negedge clock);
    check("reset_read", avm.read, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_id_value", id_value, 32'd0);
    reset = 1'b0;

    run_check("auto_start", 0, 0, EXP_ID, EXP_TS, 1'b0, 0);
    run_check("bad_id", 0, 0, 32'd49154, EXP_TS, 1'b1, 0);
    run_check("ts_wait3", 0, 3, EXP_ID, EXP_TS, 1'b1, 0);
    run_check("limit_accept", T, T, EXP_ID, EXP_TS, 1'b1, 0);
    run_check("id_stall_timeout", 20, 0, EXP_ID, EXP_TS, 1'b1, 0);
    run_check("ts_stall_timeout", 1, T + 1, EXP_ID, EXP_TS, 1'b1, 0);
    run_check("start_in_rd_ts", 0, 0, EXP_ID, EXP_TS, 1'b1, 2);
    run_check("bad_ts", 2, 0, EXP_ID, 32'd1531282208, 1'b1, 0);

    // Reset in the middle of an ID read, then the auto-start re-runs the check.
    start = 1'b1;
    avm.waitrequest = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("rst_mid_read_active", avm.read, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_read", avm.read, 1'b0);
    check("rst_address", avm.address, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_id_ok", id_ok, 1'b0);
    check("rst_ts_ok", ts_ok, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_id_value", id_value, 32'd0);
    check("rst_ts_value", ts_value, 32'd0);
    reset = 1'b0;
    run_check("auto_after_reset", 0, 0, EXP_ID, EXP_TS, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      wid = $urandom_range(0, 6);
      wts = $urandom_range(0, 6);
      did = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      dts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      run_check($sformatf("rand%0d", i), wid, wts, did, dts, 1'b1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
